// File: rtl/ofm_wb_pkg.sv
// ofm_wb_pkg: shared types and constants for the OFM write-back stage.
//   LANE_W / LANES / DW : beat geometry (8 lanes x 32 bits = 256 bits)
//   ofm_wb_state_t      : tile-level FSM states
//   last_row_idx()      : converts a programmed row count into the index of
//                         the final row (a count of 0 is handled as 1)
package ofm_wb_pkg;

  localparam int LANE_W = 32;
  localparam int LANES  = 8;
  localparam int DW     = LANES * LANE_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ofm_wb_state_t;

  function automatic logic [9:0] last_row_idx(input logic [9:0] num_rows);
    return (num_rows == 10'd0) ? 10'd0 : (num_rows - 10'd1);
  endfunction

endpackage

// File: rtl/ofm_wb_if.sv
// ofm_wb_if: request/grant write port into the OFM SRAM.
//   mem_req   : write-queue head is valid
//   mem_gnt   : SRAM accepts the head this cycle
//   mem_addr  : SRAM word address of the head
//   mem_wdata : head data (one 256-bit beat)
// Modports: master = write-back stage, slave = SRAM side.
interface ofm_wb_if
  import ofm_wb_pkg::*;
#(
  parameter int AW = 16
);

  logic          mem_req;
  logic          mem_gnt;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  modport master (
    output mem_req,
    output mem_addr,
    output mem_wdata,
    input  mem_gnt
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  mem_wdata,
    output mem_gnt
  );

endinterface

// File: rtl/ofm_wb_fifo.sv
// wb_fifo: small synchronous show-ahead FIFO holding {address, data} words.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/level only)
//   push       : write push_data (accepted when not full, or full with a pop)
//   push_data  : word to enqueue
//   pop        : retire the head (ignored when empty)
//   head_data  : current head word, valid whenever empty is low
//   full/empty : occupancy flags
//   level      : number of stored words
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo #(
  parameter int W     = 272,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_reg [DEPTH];
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW:0]   level_reg,  level_next;
  logic          push_ok, pop_ok;

  assign full  = (level_reg == (PW+1)'(DEPTH));
  assign empty = (level_reg == '0);
  assign level = level_reg;

  // When full, the slot being written is the one being popped; the head is
  // read before the edge, so the old word still leaves intact.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign head_data = mem_reg[rd_ptr_reg];

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    if (push_ok) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (pop_ok)  rd_ptr_next = rd_ptr_reg + 1'b1;
    level_next = level_reg + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop_ok};
  end

  // Storage needs no reset: the level counter decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
    end
  end

endmodule

// File: rtl/ofm_wb.sv
// ofm_wb: output-feature-map write-back stage behind the par2ser serializer.
// Stores the first KEEP_BEATS beats of every BEATS_PER_ROW-beat row into the
// OFM SRAM at row_base + beat index, discarding the trailing padding beats.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : one-cycle pulse, latches config and begins a tile
//   base_addr, row_stride : address of row 0 beat 0, increment per row
//   num_rows              : rows per tile (0 handled as 1)
//   wen, din              : upstream beat strobe and data (no backpressure)
//   mem                   : ofm_wb_if master (mem_req/mem_gnt/mem_addr/mem_wdata)
//   busy                  : tile in progress (through the done cycle)
//   done                  : one-cycle end-of-tile pulse
//   ovf                   : sticky dropped-beat / unexpected-wen flag
// Build option: OFM_WB_RELU_EN clamps negative lanes to zero at the push.
module ofm_wb
  import ofm_wb_pkg::*;
#(
  parameter int AW            = 16,
  parameter int BEATS_PER_ROW = 8,
  parameter int KEEP_BEATS    = 7,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] row_stride,
  input  logic [9:0]    num_rows,
  input  logic          wen,
  input  logic [DW-1:0] din,
  ofm_wb_if.master      mem,
  output logic          busy,
  output logic          done,
  output logic          ovf
);

  localparam int BCW = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
  localparam int FPW = $clog2(FIFO_DEPTH);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS_PER_ROW - 1);
  localparam logic [FPW:0]   LEVEL_ONE = (FPW+1)'(1);

  ofm_wb_state_t   state_reg, state_next;
  logic [AW-1:0]   row_base_reg,   row_base_next;
  logic [AW-1:0]   row_stride_reg, row_stride_next;
  logic [9:0]      last_row_reg,   last_row_next;
  logic [9:0]      row_cnt_reg,    row_cnt_next;
  logic [BCW-1:0]  beat_cnt_reg,   beat_cnt_next;
  logic            ovf_reg,        ovf_next;

  logic            beat_in_run;
  logic            keep_beat;
  logic            push_req;
  logic            pop;
  logic            row_end;
  logic [AW-1:0]   push_addr;
  logic [DW-1:0]   push_data;
  logic [AW+DW-1:0] fifo_head;
  logic            fifo_full, fifo_empty;
  logic [FPW:0]    fifo_level;

  assign beat_in_run = (state_reg == RUN) && wen;
  assign keep_beat   = (32'(beat_cnt_reg) < KEEP_BEATS);
  assign push_req    = beat_in_run && keep_beat;
  assign row_end     = (beat_cnt_reg == LAST_BEAT);
  assign pop         = mem.mem_req && mem.mem_gnt;
  assign push_addr   = row_base_reg + AW'(beat_cnt_reg);

  // Per-lane data conditioning at the push point.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
`ifdef OFM_WB_RELU_EN
    assign push_data[gi*LANE_W +: LANE_W] =
      din[gi*LANE_W + LANE_W - 1] ? '0 : din[gi*LANE_W +: LANE_W];
`else
    assign push_data[gi*LANE_W +: LANE_W] = din[gi*LANE_W +: LANE_W];
`endif
  end

  wb_fifo #(
    .W     (AW + DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_req),
    .push_data ({push_addr, push_data}),
    .pop       (pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Head is forced to zero while empty so idle outputs are deterministic.
  assign mem.mem_req   = !fifo_empty;
  assign mem.mem_addr  = fifo_empty ? '0 : fifo_head[AW+DW-1 -: AW];
  assign mem.mem_wdata = fifo_empty ? '0 : fifo_head[DW-1:0];

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);
  assign ovf  = ovf_reg;

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start) state_next = RUN;
      RUN:   if (wen && row_end && (row_cnt_reg == last_row_reg)) state_next = DRAIN;
      // Look ahead one pop so done lands in the cycle right after the last grant.
      DRAIN: if (fifo_empty || (pop && (fifo_level == LEVEL_ONE))) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Tile counters and error flag.
  always_comb begin
    row_base_next   = row_base_reg;
    row_stride_next = row_stride_reg;
    last_row_next   = last_row_reg;
    row_cnt_next    = row_cnt_reg;
    beat_cnt_next   = beat_cnt_reg;
    ovf_next        = ovf_reg;

    if ((state_reg == IDLE) && start) begin
      row_base_next   = base_addr;
      row_stride_next = row_stride;
      last_row_next   = last_row_idx(num_rows);
      row_cnt_next    = '0;
      beat_cnt_next   = '0;
      ovf_next        = 1'b0;
    end

    if (beat_in_run) begin
      if (row_end) begin
        beat_cnt_next = '0;
        row_base_next = row_base_reg + row_stride_reg;
        row_cnt_next  = row_cnt_reg + 10'd1;
      end else begin
        beat_cnt_next = beat_cnt_reg + 1'b1;
      end
    end

    // Ordered after the start clear so a beat arriving with start still flags.
    if (wen && (state_reg != RUN)) ovf_next = 1'b1;
    if (push_req && fifo_full && !pop) ovf_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      row_base_reg   <= '0;
      row_stride_reg <= '0;
      last_row_reg   <= '0;
      row_cnt_reg    <= '0;
      beat_cnt_reg   <= '0;
      ovf_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      row_base_reg   <= row_base_next;
      row_stride_reg <= row_stride_next;
      last_row_reg   <= last_row_next;
      row_cnt_reg    <= row_cnt_next;
      beat_cnt_reg   <= beat_cnt_next;
      ovf_reg        <= ovf_next;
    end
  end

endmodule

// File: tb/tb_ofm_wb.sv
// tb_ofm_wb: directed self-checking bench for ofm_wb.
// Inputs change 1 time unit after the rising edge; a negedge monitor logs
// every granted SRAM write and every done pulse.
module tb_ofm_wb;
  import ofm_wb_pkg::*;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] row_stride = '0;
  logic [9:0]    num_rows = '0;
  logic          wen = 1'b0;
  logic [DW-1:0] din = '0;
  logic          busy, done, ovf;

  ofm_wb_if #(.AW(AW)) mem_if ();

  ofm_wb #(
    .AW            (AW),
    .BEATS_PER_ROW (8),
    .KEEP_BEATS    (7),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .row_stride (row_stride),
    .num_rows   (num_rows),
    .wen        (wen),
    .din        (din),
    .mem        (mem_if),
    .busy       (busy),
    .done       (done),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  logic [AW-1:0] wr_addr_q [$];
  logic [DW-1:0] wr_data_q [$];
  logic [AW-1:0] exp_addr_q [$];
  logic [DW-1:0] exp_data_q [$];

  always @(negedge clk) begin
    if (mem_if.mem_req && mem_if.mem_gnt) begin
      wr_addr_q.push_back(mem_if.mem_addr);
      wr_data_q.push_back(mem_if.mem_wdata);
      $display("[%0t] write addr=%h lane0=%h lane1=%h", $time, mem_if.mem_addr,
               mem_if.mem_wdata[31:0], mem_if.mem_wdata[63:32]);
    end
    if (done) begin
      done_cnt++;
      $display("[%0t] done pulse", $time);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_beat(input int idx);
    logic [DW-1:0] d;
    d = '0;
    d[31:0]  = idx[31:0];
    d[63:32] = 32'h0000_5A00 + idx[31:0];
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tile(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [9:0] r);
    base_addr  = b;
    row_stride = s;
    num_rows   = r;
    start      = 1'b1;
    tick();
    start = 1'b0;
    $display("[%0t] start base=%h stride=%h rows=%0d", $time, b, s, r);
    chk("busy_after_start", busy, 1'b1);
  endtask

  // Drive n consecutive beats; the grant is held low for the first gnt_from beats.
  task automatic run_beats(input int first, input int n, input int gnt_from);
    for (int i = 0; i < n; i++) begin
      din            = mk_beat(first + i);
      wen            = 1'b1;
      mem_if.mem_gnt = (i >= gnt_from);
      tick();
    end
    wen = 1'b0;
    mem_if.mem_gnt = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int d0;
    d0 = done_cnt;
    for (int c = 0; c < 60 && done_cnt == d0; c++) tick();
    tick();
    tick();
    chk({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_busy_low"}, busy, 1'b0);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'(exp_addr_q.size()));
    for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], exp_addr_q[i]);
      chk($sformatf("%s_data%0d", tag, i), wr_data_q[i], exp_data_q[i]);
    end
    wr_addr_q.delete();
    wr_data_q.delete();
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  initial begin
    logic [DW-1:0] relu_beat;
    logic [DW-1:0] relu_exp;

    mem_if.mem_gnt = 1'b0;
    repeat (3) tick();

    // Reset state (still in reset).
    chk("rst_mem_req", mem_if.mem_req, 1'b0);
    chk("rst_mem_addr", mem_if.mem_addr, '0);
    chk("rst_mem_wdata", mem_if.mem_wdata, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1: two-row tile, grant always high.
    mem_if.mem_gnt = 1'b1;
    start_tile(16'h0100, 16'h0010, 10'd2);
    run_beats(0, 1, 0);
    chk("lat_mem_req", mem_if.mem_req, 1'b1);
    chk("lat_mem_addr", mem_if.mem_addr, 16'h0100);
    run_beats(1, 15, 0);
    for (int i = 0; i < 16; i++) begin
      if ((i % 8) < 7) begin
        exp_addr_q.push_back(16'(16'h0100 + (i / 8) * 16'h0010 + (i % 8)));
        exp_data_q.push_back(mk_beat(i));
      end
    end
    wait_done("t1");
    chk("t1_ovf", ovf, 1'b0);
    check_writes("t1");

    // 2: same tile, grant low for the first 10 beat cycles.
    mem_if.mem_gnt = 1'b0;
    start_tile(16'h0100, 16'h0010, 10'd2);
    run_beats(0, 16, 10);
    foreach (exp_data_q[k]) exp_data_q[k] = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < 4 || (i >= 10 && i <= 14)) begin
        exp_addr_q.push_back(16'(16'h0100 + (i / 8) * 16'h0010 + (i % 8)));
        exp_data_q.push_back(mk_beat(i));
      end
    end
    wait_done("t2");
    chk("t2_ovf", ovf, 1'b1);
    check_writes("t2");

    // 3: address wrap at the top of the SRAM; start also clears ovf.
    start_tile(16'hFFFE, 16'h0001, 10'd1);
    chk("t3_ovf_cleared", ovf, 1'b0);
    run_beats(0, 8, 0);
    for (int i = 0; i < 7; i++) begin
      exp_addr_q.push_back(16'(32'h0000_FFFE + i));
      exp_data_q.push_back(mk_beat(i));
    end
    wait_done("t3");
    chk("t3_ovf", ovf, 1'b0);
    check_writes("t3");

    // 4: stray wen while idle.
    din = mk_beat(99);
    wen = 1'b1;
    tick();
    wen = 1'b0;
    tick();
    chk("t4_idle_req", mem_if.mem_req, 1'b0);
    chk("t4_idle_ovf", ovf, 1'b1);
    chk("t4_idle_nwrites", 32'(wr_addr_q.size()), 32'd0);

    // 5: ReLU lanes, num_rows = 0 handled as a single row.
    start_tile(16'h0200, 16'h0000, 10'd0);
    chk("t5_ovf_cleared", ovf, 1'b0);
    relu_beat = '0;
    relu_beat[31:0]  = 32'h8000_0001;
    relu_beat[63:32] = 32'h0000_0005;
    relu_exp = relu_beat;
`ifdef OFM_WB_RELU_EN
    relu_exp[31:0] = 32'h0000_0000;
`endif
    din = relu_beat;
    wen = 1'b1;
    tick();
    run_beats(1, 7, 0);
    exp_addr_q.push_back(16'h0200);
    exp_data_q.push_back(relu_exp);
    for (int i = 1; i < 7; i++) begin
      exp_addr_q.push_back(16'(16'h0200 + i));
      exp_data_q.push_back(mk_beat(i));
    end
    wait_done("t5");
    check_writes("t5");

    // 6: reset with three queued entries.
    mem_if.mem_gnt = 1'b0;
    start_tile(16'h0300, 16'h0010, 10'd1);
    run_beats(0, 3, 99);
    mem_if.mem_gnt = 1'b0;
    chk("t6_queued_req", mem_if.mem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req", mem_if.mem_req, 1'b0);
    chk("t6_rst_addr", mem_if.mem_addr, '0);
    chk("t6_rst_busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    mem_if.mem_gnt = 1'b1;
    repeat (6) tick();
    chk("t6_post_req", mem_if.mem_req, 1'b0);
    chk("t6_post_busy", busy, 1'b0);
    chk("t6_post_done", done, 1'b0);
    chk("t6_post_nwrites", 32'(wr_addr_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
